// File: rtl/dma_dsc_byp_ctrl_if.sv
// ============================================================================
// Module  : dma_dsc_byp_ctrl_if
// Brief   : Command stream and XDMA descriptor-bypass signal bundle.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dma_dsc_byp_ctrl_if;
    logic        s_cmd_valid;
    logic        s_cmd_ready;
    logic [63:0] s_cmd_address;
    logic [31:0] s_cmd_length;
    logic        dsc_byp_ready;
    logic        dsc_byp_load;
    logic [63:0] dsc_byp_addr;
    logic [31:0] dsc_byp_len;

    // master: the splitter itself; slave: the surrounding command source and XDMA
    modport master (
        input  s_cmd_valid, s_cmd_address, s_cmd_length, dsc_byp_ready,
        output s_cmd_ready, dsc_byp_load, dsc_byp_addr, dsc_byp_len
    );
    modport slave (
        output s_cmd_valid, s_cmd_address, s_cmd_length, dsc_byp_ready,
        input  s_cmd_ready, dsc_byp_load, dsc_byp_addr, dsc_byp_len
    );
endinterface

`default_nettype wire

// File: rtl/dma_dsc_byp_ctrl.sv
// ============================================================================
// Module  : dma_dsc_byp_ctrl
// Brief   : Splits DMA commands into BOUNDARY-safe bypass descriptors with credit limiting.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_dsc_byp_ctrl #(
    parameter int BOUNDARY        = 4096,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = 8
) (
    input  wire logic                 pcie_clk,
    input  wire logic                 pcie_aresetn,
    dma_dsc_byp_ctrl_if.master        bus,
    input  wire logic                 dsc_done,
    output logic [CNT_WIDTH-1:0]      outstanding,
    output logic                      busy,
    output logic                      err_zero_len,
    output logic                      err_underflow
);

    localparam int                   c_OFS_W   = $clog2(BOUNDARY);
    localparam logic [32:0]          c_BND33   = 33'(BOUNDARY);
    localparam logic [CNT_WIDTH-1:0] c_MAX_OUT = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] c_ONE     = CNT_WIDTH'(1);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_ISSUE = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [63:0]          r_cur_addr;
    logic [31:0]          r_remaining;
    logic [CNT_WIDTH-1:0] r_outstanding;
    logic                 r_cmd_ready;
    logic                 r_err_zero;
    logic                 r_err_unf;

    logic                 w_accept;
    logic                 w_zero;
    logic [c_OFS_W-1:0]   w_ofs;
    logic [32:0]          w_room;
    logic [31:0]          w_chunk;
    logic                 w_last;
    logic                 w_load;

    assign w_accept = bus.s_cmd_valid && r_cmd_ready;
    assign w_zero   = (bus.s_cmd_length == 32'd0);
    assign w_ofs    = r_cur_addr[c_OFS_W-1:0];
    assign w_room   = c_BND33 - {{(33-c_OFS_W){1'b0}}, w_ofs};
    assign w_chunk  = ({1'b0, r_remaining} < w_room) ? r_remaining : w_room[31:0];
    assign w_last   = (r_remaining == w_chunk);

    always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
        if (!pcie_aresetn) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (w_accept && !w_zero) w_state_nxt = c_S_ISSUE;
            c_S_ISSUE: if (w_load && w_last)    w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        if (r_state == c_S_ISSUE) begin
            w_load = bus.dsc_byp_ready && (r_outstanding < c_MAX_OUT);
        end
    end

    // The final chunk leaves cur_addr/remaining untouched so addr/len hold after the command.
    always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
        if (!pcie_aresetn) begin
            r_cur_addr  <= 64'd0;
            r_remaining <= 32'd0;
            r_cmd_ready <= 1'b0;
            r_err_zero  <= 1'b0;
        end else begin
            r_cmd_ready <= (r_state == c_S_IDLE) && (w_state_nxt == c_S_IDLE);
            r_err_zero  <= w_accept && w_zero;
            if (w_accept && !w_zero) begin
                r_cur_addr  <= bus.s_cmd_address;
                r_remaining <= bus.s_cmd_length;
            end else if (w_load && !w_last) begin
                r_cur_addr  <= r_cur_addr + {32'd0, w_chunk};
                r_remaining <= r_remaining - w_chunk;
            end
        end
    end

    always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
        if (!pcie_aresetn) begin
            r_outstanding <= '0;
            r_err_unf     <= 1'b0;
        end else begin
            if (w_load && !dsc_done) begin
                r_outstanding <= r_outstanding + c_ONE;
            end else if (dsc_done && !w_load) begin
                if (r_outstanding == '0) begin
                    r_err_unf <= 1'b1;
                end else begin
                    r_outstanding <= r_outstanding - c_ONE;
                end
            end
        end
    end

    assign bus.s_cmd_ready  = r_cmd_ready;
    assign bus.dsc_byp_load = w_load;
    assign bus.dsc_byp_addr = r_cur_addr;
    assign bus.dsc_byp_len  = w_chunk;

    assign outstanding   = r_outstanding;
    assign busy          = (r_state != c_S_IDLE) || (r_outstanding != '0);
    assign err_zero_len  = r_err_zero;
    assign err_underflow = r_err_unf;

endmodule

`default_nettype wire

// File: doc/dma_dsc_byp_ctrl.md
Name: dma_dsc_byp_ctrl

Overview:
- Sits between the user-side DMA command stream (64-bit address, 32-bit length) and one XDMA descriptor-bypass channel (c2h or h2c); one instance per direction.
- Splits each command into descriptors that never cross a BOUNDARY-aligned address line.
- Drives the bypass load/ready handshake.
- Limits outstanding descriptors using per-descriptor completion pulses derived from the channel status.

Parameters:
- BOUNDARY, 4096, split granularity in bytes; power of two, 64..65536.
- MAX_OUTSTANDING, 8, maximum descriptors issued but not completed; 1..255.
- CNT_WIDTH, 8, width of the outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- pcie_clk  in  1  sole clock.
- pcie_aresetn  in  1  asynchronous active-low reset.
- s_cmd_valid  in  1  command valid.
- s_cmd_ready  out  1  command ready.
- s_cmd_address  in  64  byte address.
- s_cmd_length  in  32  byte length.
- dsc_byp_ready  in  1  XDMA bypass ready.
- dsc_byp_load  out  1  descriptor load.
- dsc_byp_addr  out  64  descriptor address.
- dsc_byp_len  out  32  descriptor length.
- dsc_done  in  1  one-cycle pulse per completed descriptor.
- outstanding  out  CNT_WIDTH  current outstanding descriptor count.
- busy  out  1  high when not IDLE or outstanding != 0.
- err_zero_len  out  1  one-cycle pulse when a zero-length command is dropped.
- err_underflow  out  1  sticky; set by dsc_done while outstanding == 0.

Behaviour:
- Clock and reset: single clock pcie_clk; reset pcie_aresetn is asynchronous, active-low.
- Reset values: state IDLE; s_cmd_ready 0 during reset, 1 from the first cycle after deassertion; dsc_byp_load 0; dsc_byp_addr 0; dsc_byp_len 0; outstanding 0; busy 0; err_zero_len 0; err_underflow 0.
- States: IDLE, ISSUE.
- IDLE:
  - s_cmd_ready = 1.
  - Accept on s_cmd_valid && s_cmd_ready.
  - length == 0: drop the command, pulse err_zero_len next cycle, stay IDLE.
  - length > 0: latch cur_addr = address and remaining = length; go to ISSUE.
- ISSUE:
  - s_cmd_ready = 0.
  - room = BOUNDARY - cur_addr[log2(BOUNDARY)-1:0], computed 33 bits wide.
  - chunk = min(remaining, room).
  - dsc_byp_addr = cur_addr; dsc_byp_len = chunk. Both are combinational from registers and stable until accepted.
  - dsc_byp_load = dsc_byp_ready && (outstanding < MAX_OUTSTANDING). Load is never asserted while ready is low.
  - On load: cur_addr += chunk (64-bit wrap permitted); remaining -= chunk.
  - If remaining == chunk, return to IDLE; s_cmd_ready rises the following cycle (one-cycle bubble).
- Latency: command accepted at cycle N → first possible dsc_byp_load at cycle N+1. Back-to-back descriptors of one command issue every cycle while ready and credit allow.
- Outstanding counter:
  - +1 on load, −1 on dsc_done.
  - Both in the same cycle: unchanged.
  - dsc_done at 0: counter stays 0 and err_underflow is set. err_underflow clears only on reset.
  - The counter never exceeds MAX_OUTSTANDING.
- Outside ISSUE: dsc_byp_addr/len hold their last values and dsc_byp_load = 0.
- Reset mid-command: the remaining descriptors are discarded and all state returns to reset values. No descriptor may be loaded in the cycle of reset deassertion.
- Full-length command: length 0xFFFFFFFF is legal; remaining arithmetic is 32-bit and never underflows.

Test Plan:
- Single descriptor: address 0x1000, length 0x100, ready held 1 → exactly one load at cycle N+1 with addr 0x1000, len 0x100; s_cmd_ready high again at N+3.
- Boundary cross: address 0xF80, length 0x200 → two loads: (0xF80, 0x80), then (0x1000, 0x180) on consecutive cycles.
- Multi-chunk with stalls: address 0x0, length 0x3000, ready toggling 1/0 → three loads of 0x1000 at 0x0, 0x1000, 0x2000; no load while ready is 0; addr/len stable across stalls.
- Credit limit: MAX_OUTSTANDING = 4, address 0, length 0x6000, dsc_done held 0 → exactly 4 loads, then outstanding = 4 with load low. One dsc_done pulse → 5th load the next cycle. Simultaneous load and done leaves outstanding at 4.
- Errors: length 0 → no load, err_zero_len pulses once, s_cmd_ready stays 1. dsc_done with outstanding 0 → err_underflow = 1 and remains set.
- Reset mid-operation: assert pcie_aresetn = 0 after the 1st of 3 descriptors → outputs at reset values immediately; after release, no further loads until a new command arrives.
